matrix_vector_loader: RTL and testbench
=======================================

Name: matrix_vector_loader

Overview:
Upstream input stage for the pipelined matrix_mult_vector datapath. It accepts a serial stream of data_width-bit elements over a valid/ready handshake. The elements form one frame: m_rows*n_columns matrix elements in row-major order, then n_columns vector elements. The block packs the frame into the flat matrix_inp/vector_inp buses, then presents the packed frame downstream under its own valid/ready handshake.

Parameters:
m_rows, 3, number of matrix rows
n_columns, 3, number of matrix columns; also the vector length
data_width, 3, bits per element

Ports:
clk  input  1  single clock; all state updates on the posedge
rst_n  input  1  asynchronous, active-low reset
abort  input  1  synchronous frame abort; discards the partial or held frame
in_data  input  data_width  element value
in_valid  input  1  in_data is valid
in_ready  output  1  loader can accept an element this cycle
matrix_out  output  m_rows*n_columns*data_width  packed matrix; feeds matrix_inp
vector_out  output  n_columns*data_width  packed vector; feeds vector_inp
out_valid  output  1  packed frame is complete and held stable
out_ready  input  1  downstream accepts the frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=LOAD_MAT; element counters=0.
  - matrix_out=0, vector_out=0, out_valid=0, in_ready=1.
  - Reset mid-frame discards all partial data.
- Accept rule: an element is accepted when in_valid && in_ready on a clk edge. No element is accepted in any other cycle.
- Packing:
  - Matrix element (r,c), with r,c zero-based, lands at matrix_out[((r*n_columns)+c)*data_width +: data_width].
  - Row r therefore occupies the num_bits=n_columns*data_width slice starting at r*num_bits.
  - Vector element c lands at vector_out[c*data_width +: data_width].
  - No sign or width conversion; bits are copied verbatim.
- Counters: row and column (or a flat index) sized by clog2 of the maximum value, minimum 1 bit. The column counter wraps to 0 after n_columns-1 and increments the row.
- State LOAD_MAT: in_ready=1, out_valid=0.
  - On accepting element m_rows*n_columns-1, go to LOAD_VEC and clear the column counter.
- State LOAD_VEC: in_ready=1, out_valid=0.
  - On accepting element n_columns-1, go to PRESENT.
- State PRESENT: in_ready=0, out_valid=1.
  - matrix_out and vector_out are held constant; in_valid is ignored.
  - On out_valid && out_ready, go to LOAD_MAT with counters=0.
  - out_valid=0 and in_ready=1 from the next cycle.
- Latency:
  - Last vector element accepted at edge k -> out_valid=1 after edge k.
  - With out_ready held high, the frame transfers at edge k+1 and in_ready returns after edge k+1.
  - Steady-state throughput: one frame per m_rows*n_columns+n_columns+1 cycles.
- Registered outputs: in_ready and out_valid are registers. There is no combinational path from out_ready or in_valid to in_ready.
- Outputs between frames: matrix_out and vector_out keep their last values while loading; they are meaningful only while out_valid=1.
- Abort (synchronous, any state):
  - Next state LOAD_MAT, counters=0, out_valid=0, in_ready=1.
  - Data registers are not cleared.
  - An element presented in the same cycle as abort is dropped, not accepted.
  - abort outranks out_ready in PRESENT: the frame is not transferred.
- Degenerate sizes: m_rows=1 and/or n_columns=1 must work. The LOAD_MAT->LOAD_VEC and LOAD_VEC->PRESENT transitions then follow the first accepted element of that phase.

Test Plan:
1. Defaults, out_ready=1. Stream 0,1,2,3,4,5,6,7,0 then 1,2,3, no gaps -> out_valid high exactly one cycle, the cycle after the 12th accept, with matrix_out=27'o076543210 and vector_out=9'o321. in_ready low only that cycle.
2. Same frame, out_ready=0 for 5 cycles after out_valid rises, with in_valid held high and in_data=7 -> out_valid and outputs stable for all 5 cycles, in_ready=0, no element accepted. Transfer on the first out_ready=1 cycle.
3. Random in_valid gaps, with the frame from scenario 1 -> identical packed result; the accept count equals 12 exactly.
4. Assert abort after 5 matrix elements, then stream a full frame of all 5s -> matrix_out=27'o555555555, vector_out=9'o555, and no residue from the aborted elements.
5. Drop rst_n asynchronously, mid-clock, during LOAD_VEC -> immediately out_valid=0, in_ready=1, outputs=0. Then a full frame loads correctly.
6. Parameters m_rows=1, n_columns=1, data_width=4. Stream 9,6 -> matrix_out=4'h9 and vector_out=4'h6 with out_valid the cycle after the 2nd accept; back-to-back frames run at 3 cycles/frame.

Source files
------------

// File: rtl/matrix_vector_loader.sv
// Serial-to-parallel input stage: packs one matrix+vector frame from an element
// stream, then holds it for the downstream datapath until it is taken.
module matrix_vector_loader #(
  parameter int m_rows     = 3,
  parameter int n_columns  = 3,
  parameter int data_width = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   abort,
  input  logic [data_width-1:0]                  in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [m_rows*n_columns*data_width-1:0] matrix_out,
  output logic [n_columns*data_width-1:0]        vector_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [1:0]                             dbg_state
);

  // Handshakes: a transfer happens on a clk edge where valid && ready are both
  // high; in_ready and out_valid are registers, so neither depends on inputs
  // combinationally within the same cycle.

  localparam int MAT_N = m_rows * n_columns;
  localparam int MW    = (MAT_N > 1) ? $clog2(MAT_N) : 1;
  localparam int VW    = (n_columns > 1) ? $clog2(n_columns) : 1;

  typedef enum logic [1:0] {
    LOAD_MAT = 2'd0,
    LOAD_VEC = 2'd1,
    PRESENT  = 2'd2
  } state_e;

  state_e                                 state_q;
  logic [MW-1:0]                          mat_idx_q;
  logic [VW-1:0]                          vec_idx_q;
  logic [m_rows*n_columns*data_width-1:0] matrix_q;
  logic [n_columns*data_width-1:0]        vector_q;
  logic                                   in_ready_q;
  logic                                   out_valid_q;
  logic                                   accept;

  assign accept = in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_MAT;
      mat_idx_q   <= '0;
      vec_idx_q   <= '0;
      matrix_q    <= '0;
      vector_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      // Abort wins over any handshake; packed data is left as-is.
      state_q     <= LOAD_MAT;
      mat_idx_q   <= '0;
      vec_idx_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_MAT: begin
          if (accept) begin
            for (int i = 0; i < MAT_N; i++) begin
              if (mat_idx_q == MW'(i)) matrix_q[i*data_width +: data_width] <= in_data;
            end
            if (mat_idx_q == MW'(MAT_N - 1)) begin
              state_q   <= LOAD_VEC;
              mat_idx_q <= '0;
              vec_idx_q <= '0;
            end else begin
              mat_idx_q <= mat_idx_q + MW'(1);
            end
          end
        end
        LOAD_VEC: begin
          if (accept) begin
            for (int c = 0; c < n_columns; c++) begin
              if (vec_idx_q == VW'(c)) vector_q[c*data_width +: data_width] <= in_data;
            end
            if (vec_idx_q == VW'(n_columns - 1)) begin
              state_q     <= PRESENT;
              vec_idx_q   <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              vec_idx_q <= vec_idx_q + VW'(1);
            end
          end
        end
        PRESENT: begin
          if (out_valid_q && out_ready) begin
            state_q     <= LOAD_MAT;
            mat_idx_q   <= '0;
            vec_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOAD_MAT;
          mat_idx_q   <= '0;
          vec_idx_q   <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign matrix_out = matrix_q;
  assign vector_out = vector_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_matrix_vector_loader.sv
// Directed bench for matrix_vector_loader: default 3x3x3 instance plus a
// degenerate 1x1x4 instance sharing the clock and reset.
module tb_matrix_vector_loader;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic [2:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] matrix_out;
  logic [8:0]  vector_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  logic        abort2;
  logic [3:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic [3:0]  matrix_out2;
  logic [3:0]  vector_out2;
  logic        out_valid2;
  logic        out_ready2;
  logic [1:0]  dbg_state2;

  int          checks;
  int          errors;
  int          acc_cnt;
  logic [2:0]  frame_v[12];
  logic [26:0] held_m;
  logic [8:0]  held_v;

  matrix_vector_loader #(.m_rows(3), .n_columns(3), .data_width(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .matrix_out(matrix_out), .vector_out(vector_out),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  matrix_vector_loader #(.m_rows(1), .n_columns(1), .data_width(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .matrix_out(matrix_out2), .vector_out(vector_out2),
    .out_valid(out_valid2), .out_ready(out_ready2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) if (in_valid && in_ready) acc_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams frame_v; optional random idle cycles before each element.
  task automatic send_frame(input logic [26:0] exp_m, input logic [8:0] exp_v, input bit gaps);
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          step();
          check("gap_no_valid", {63'd0, out_valid}, 64'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = frame_v[i];
      step();
      if (i < 11) begin
        check("load_out_valid", {63'd0, out_valid}, 64'd0);
        check("load_in_ready", {63'd0, in_ready}, 64'd1);
      end
    end
    in_valid = 1'b0;
    check("frame_out_valid", {63'd0, out_valid}, 64'd1);
    check("frame_in_ready", {63'd0, in_ready}, 64'd0);
    check("frame_state", {62'd0, dbg_state}, 64'd2);
    check("frame_matrix", {37'd0, matrix_out}, {37'd0, exp_m});
    check("frame_vector", {55'd0, vector_out}, {55'd0, exp_v});
  endtask

  initial begin
    checks = 0; errors = 0; acc_cnt = 0;
    rst_n = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    abort2 = 1'b0; in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    #12;
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_matrix", {37'd0, matrix_out}, 64'd0);
    check("rst_vector", {55'd0, vector_out}, 64'd0);
    check("rst2_in_ready", {63'd0, in_ready2}, 64'd1);
    rst_n = 1'b1;

    // 1: gapless frame, out_ready high
    for (int i = 0; i < 12; i++) frame_v[i] = 3'((i < 9) ? (i % 8) : (i - 8));
    acc_cnt = 0;
    send_frame(27'o076543210, 9'o321, 1'b0);
    step();
    check("s1_xfer_out_valid", {63'd0, out_valid}, 64'd0);
    check("s1_xfer_in_ready", {63'd0, in_ready}, 64'd1);
    check("s1_acc_cnt", 64'(acc_cnt), 64'd12);

    // 2: downstream stalls for 5 cycles while in_valid stays high
    acc_cnt = 0;
    out_ready = 1'b0;
    send_frame(27'o076543210, 9'o321, 1'b0);
    held_m = 27'o076543210;
    held_v = 9'o321;
    in_valid = 1'b1;
    in_data  = 3'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("s2_hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("s2_hold_matrix", {37'd0, matrix_out}, {37'd0, held_m});
      check("s2_hold_vector", {55'd0, vector_out}, {55'd0, held_v});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("s2_xfer_out_valid", {63'd0, out_valid}, 64'd0);
    check("s2_xfer_in_ready", {63'd0, in_ready}, 64'd1);
    check("s2_acc_cnt", 64'(acc_cnt), 64'd12);

    // 3: random idle gaps on the input side
    acc_cnt = 0;
    send_frame(27'o076543210, 9'o321, 1'b1);
    check("s3_acc_cnt", 64'(acc_cnt), 64'd12);
    step();
    check("s3_xfer_out_valid", {63'd0, out_valid}, 64'd0);

    // 4: abort after 5 matrix elements, element in the abort cycle dropped
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 3'd2;
      step();
    end
    abort   = 1'b1;
    in_data = 3'd3;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("s4_abort_state", {62'd0, dbg_state}, 64'd0);
    check("s4_abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("s4_abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("s4_abort_data_kept", {37'd0, matrix_out}, {37'd0, 27'o076522222});
    for (int i = 0; i < 12; i++) frame_v[i] = 3'd5;
    send_frame(27'o555555555, 9'o555, 1'b0);
    step();

    // 4b: abort outranks out_ready while presenting
    for (int i = 0; i < 12; i++) frame_v[i] = 3'd1;
    send_frame(27'o111111111, 9'o111, 1'b0);
    abort = 1'b1;
    acc_cnt = 0;
    step();
    abort = 1'b0;
    check("s4b_abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("s4b_abort_state", {62'd0, dbg_state}, 64'd0);
    check("s4b_abort_in_ready", {63'd0, in_ready}, 64'd1);

    // 5: asynchronous reset mid-clock during LOAD_VEC
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 3'd6;
      step();
    end
    in_valid = 1'b0;
    check("s5_pre_state", {62'd0, dbg_state}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("s5_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("s5_rst_matrix", {37'd0, matrix_out}, 64'd0);
    check("s5_rst_vector", {55'd0, vector_out}, 64'd0);
    check("s5_rst_state", {62'd0, dbg_state}, 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) frame_v[i] = 3'((i * 3 + 1) % 8);
    send_frame(27'o163052741, 9'o274, 1'b0);
    step();
    check("s5_xfer_out_valid", {63'd0, out_valid}, 64'd0);

    // 6: 1x1 instance, back-to-back frames at 3 cycles each
    in_valid2 = 1'b1;
    in_data2  = 4'h9;
    step();
    check("s6_f1_e1_out_valid", {63'd0, out_valid2}, 64'd0);
    check("s6_f1_e1_state", {62'd0, dbg_state2}, 64'd1);
    in_data2 = 4'h6;
    step();
    check("s6_f1_out_valid", {63'd0, out_valid2}, 64'd1);
    check("s6_f1_in_ready", {63'd0, in_ready2}, 64'd0);
    check("s6_f1_matrix", {60'd0, matrix_out2}, 64'h9);
    check("s6_f1_vector", {60'd0, vector_out2}, 64'h6);
    in_data2 = 4'h3;
    step();
    check("s6_xfer_out_valid", {63'd0, out_valid2}, 64'd0);
    check("s6_xfer_in_ready", {63'd0, in_ready2}, 64'd1);
    check("s6_xfer_matrix_kept", {60'd0, matrix_out2}, 64'h9);
    step();
    check("s6_f2_e1_out_valid", {63'd0, out_valid2}, 64'd0);
    in_data2 = 4'hc;
    step();
    check("s6_f2_out_valid", {63'd0, out_valid2}, 64'd1);
    check("s6_f2_matrix", {60'd0, matrix_out2}, 64'h3);
    check("s6_f2_vector", {60'd0, vector_out2}, 64'hc);
    in_valid2 = 1'b0;
    step();
    check("s6_f2_xfer_out_valid", {63'd0, out_valid2}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
